// File: rtl/burst_pkg.sv
// Shared types and width helpers for the burst scheduler slice.
// Imported by the arbiter and the scheduler top.
package burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BEAT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at ptr and wraps, so the first set req bit wins.
module rr_arbiter
  import burst_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx
);

  // First requester at or after ptr, in circular order.
  always_comb begin
    int  i;
    logic found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    i       = 0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!found && req[i]) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/burst_scheduler.sv
// Round-robin burst scheduler: start pulse, then BURST_LEN
// non-zero beats from the granted requester, then GAP_CYC idle.
module burst_scheduler
  import burst_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DW        = 4,
  parameter int BURST_LEN = 4,
  parameter int GAP_CYC   = 1,
  parameter int ZERO_SUB  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    beat_ack,
  output logic                start,
  output logic [DW-1:0]       data,
  output logic                data_valid,
  output logic                busy,
  output logic                err_zero
);

  localparam int IW = clog2_min1(N_REQ);
  localparam int CW = clog2_min1(BURST_LEN);
  localparam int GW = clog2_min1(GAP_CYC);

  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [N_REQ-1:0]  goh_q, goh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [N_REQ-1:0]  arb_oh;
  logic [IW-1:0]     arb_idx;
  logic [DW-1:0]     beat_raw;
  logic              beat_zero;
  logic              in_beat;
  logic              in_grant;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx)
  );

  // Next-state: latch the winner in IDLE, then run a fixed burst.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    goh_d   = goh_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = arb_idx;
          goh_d   = arb_oh;
          ptr_d   = (arb_idx == IDX_LAST) ? '0
                    : arb_idx + 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BEAT;
      end
      BEAT: begin
        if (cnt_q == CNT_LAST) begin
          gap_d   = '0;
          state_d = (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers; reset aborts any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      goh_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      goh_q   <= goh_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign beat_raw  = req_data[int'(win_q)*DW +: DW];
  assign beat_zero = (beat_raw == '0);
  assign in_beat   = (state_q == BEAT);
  assign in_grant  = (state_q == START) || in_beat;

  // Outputs decode straight from state so reset clears them at once.
  always_comb begin
    start      = (state_q == START);
    data_valid = in_beat;
    busy       = (state_q != IDLE);
    gnt        = in_grant ? goh_q : '0;
    beat_ack   = in_beat ? goh_q : '0;
    err_zero   = in_beat && beat_zero;
    data       = '0;
    if (in_beat) begin
      data = beat_zero ? DW'(ZERO_SUB) : beat_raw;
    end
  end

endmodule

// File: tb/tb_burst_scheduler.sv
// Scoreboard bench for burst_scheduler: directed bursts push
// expected starts/beats, a negedge monitor pops and compares.
module tb_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] req_data;
  logic [1:0] gnt;
  logic [1:0] beat_ack;
  logic       start;
  logic [3:0] data;
  logic       data_valid;
  logic       busy;
  logic       err_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run   = 0;
  bit sb_on = 1'b1;

  typedef struct {
    int         cyc;
    logic [1:0] g;
  } st_t;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic [1:0] a;
    logic       e;
  } bt_t;

  st_t exp_s[$];
  bt_t exp_b[$];

  burst_scheduler #(
    .N_REQ     (2),
    .DW        (4),
    .BURST_LEN (4),
    .GAP_CYC   (1),
    .ZERO_SUB  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .beat_ack   (beat_ack),
    .start      (start),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .err_zero   (err_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_start(input int c, input logic [1:0] g);
    st_t s;
    s.cyc = c;
    s.g   = g;
    exp_s.push_back(s);
  endtask

  task automatic push_beat(input int c, input int w,
                           input logic [3:0] d);
    bt_t b;
    b.cyc = c;
    b.a   = 2'b01 << w;
    b.e   = (d == 4'd0);
    b.d   = (d == 4'd0) ? 4'd1 : d;
    exp_b.push_back(b);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pops on output.
  always @(negedge clk) begin
    st_t s;
    bt_t b;
    if (rst) begin
      run = 0;
    end else begin
      if (run > 0) begin
        chk("burst_run", {31'd0, data_valid && data != 4'd0}, 32'd1);
        run--;
      end else if (data_valid) begin
        chk("extra_beat", {31'd0, data_valid}, 32'd0);
      end
      if (start) begin
        chk("start_vs_valid", {31'd0, data_valid}, 32'd0);
        run = 4;
      end
      chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      chk("ack_vs_gnt", {30'd0, beat_ack},
          {30'd0, data_valid ? gnt : 2'b00});
      if (err_zero)
        chk("err_data", {27'd0, data_valid, data}, {27'd0, 1'b1, 4'd1});
      if (sb_on && start) begin
        if (exp_s.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          s = exp_s.pop_front();
          chk("start_cyc", cyc, s.cyc);
          chk("start_gnt", {30'd0, gnt}, {30'd0, s.g});
        end
      end
      if (sb_on && data_valid) begin
        if (exp_b.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_b.pop_front();
          chk("beat_cyc", cyc, b.cyc);
          chk("beat_data", {28'd0, data}, {28'd0, b.d});
          chk("beat_ack", {30'd0, beat_ack}, {30'd0, b.a});
          chk("beat_gnt", {30'd0, gnt}, {30'd0, b.a});
          chk("beat_err", {31'd0, err_zero}, {31'd0, b.e});
        end
      end
    end
  end

  // One isolated burst; req drops at tick 'drop' after issue.
  task automatic burst(input logic [1:0] r, input int w,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3,
                       input int drop);
    logic [3:0] d [4];
    int t;
    d = '{d0, d1, d2, d3};
    t = cyc;
    req = r;
    push_start(t + 1, 2'b01 << w);
    for (int k = 0; k < 4; k++) push_beat(t + 2 + k, w, d[k]);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == drop) req = 2'b00;
      if (k >= 2) req_data[w*4 +: 4] = d[k-2];
    end
    tick();
    chk("busy_in_gap", {31'd0, busy}, 32'd1);
    chk("gap_no_valid", {31'd0, data_valid}, 32'd0);
    tick();
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    int wseq [3];
    rst      = 1'b1;
    req      = 2'b00;
    req_data = 8'h00;
    #2;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data", {28'd0, data}, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_zero}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic burst from requester 0; ptr becomes 1.
    burst(2'b01, 0, 4'd4, 4'd5, 4'd1, 4'd3, 1);
    repeat (2) tick();

    // Zero last beat is replaced by 1 with err_zero.
    burst(2'b01, 0, 4'd4, 4'd5, 4'd1, 4'd0, 1);
    repeat (2) tick();

    // Both requesting: ptr=1 so grants go 10, 01, 10.
    wseq = '{1, 0, 1};
    t = cyc;
    req = 2'b11;
    req_data = 8'h72;
    for (int b = 0; b < 3; b++) begin
      push_start(t + 1 + 7*b, 2'b01 << wseq[b]);
      for (int k = 0; k < 4; k++)
        push_beat(t + 2 + 7*b + k, wseq[b],
                  (wseq[b] == 1) ? 4'd7 : 4'd2);
    end
    repeat (20) tick();
    req = 2'b00;
    repeat (2) tick();
    chk("rr_idle_busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();

    // req0 dropped after the first beat; burst still completes.
    burst(2'b01, 0, 4'd3, 4'd6, 4'd9, 4'd12, 2);
    repeat (4) tick();

    // Reset during the second beat, then req1 from ptr 0.
    t = cyc;
    req = 2'b01;
    req_data = 8'h08;
    push_start(t + 1, 2'b01);
    push_beat(t + 2, 0, 4'd8);
    tick();
    tick();
    tick();
    req_data[3:0] = 4'd9;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_start", {31'd0, start}, 32'd0);
    chk("arst_valid", {31'd0, data_valid}, 32'd0);
    chk("arst_data", {28'd0, data}, 32'd0);
    chk("arst_gnt", {30'd0, gnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    req = 2'b10;
    req_data = 8'hA0;
    tick();
    tick();
    rst = 1'b0;
    t = cyc;
    push_start(t + 1, 2'b10);
    for (int k = 0; k < 4; k++) push_beat(t + 2 + k, 1, 4'hA);
    tick();
    req = 2'b00;
    repeat (6) tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    chk("sb_starts_left", exp_s.size(), 32'd0);
    chk("sb_beats_left", exp_b.size(), 32'd0);

    // Random traffic including zero beats; protocol checks only.
    sb_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      req      = 2'($urandom);
      req_data = 8'($urandom);
      tick();
    end
    req = 2'b00;
    repeat (10) tick();
    chk("rand_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
